// File: rtl/memory_reader_pkg.sv
// Shared types and defaults for the memory_reader read-back monitor.
package memory_reader_pkg;

    localparam int ADRS_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_READ = 2'd1,
        RD_WAIT = 2'd2
    } rd_state_t;

endpackage

// File: rtl/memory_reader_if.sv
// RAM read bus between memory_reader (master) and the shared program RAM (slave).
interface memory_reader_if #(
    parameter int ADRS_W = 8,
    parameter int DATA_W = 8
);
    logic [ADRS_W-1:0] mem_adrs;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_q;

    modport master (output mem_adrs, output mem_rd_en, input  mem_q);
    modport slave  (input  mem_adrs, input  mem_rd_en, output mem_q);
endinterface

// File: rtl/memory_reader_rise_detect.sv
// Rising-edge detector; history resets to 1 so a level held through reset is not an event.
module memory_reader_rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise
);
    logic hist;

    always_ff @(posedge clock) begin
        if (reset) hist <= 1'b1;
        else       hist <= din;
    end

    assign rise = din & ~hist;
endmodule

// File: rtl/memory_reader.sv
// Walks the program RAM one address at a time and latches each read for the debug display.
// Optional auto-scan stepping is enabled by defining MEMORY_READER_AUTOSCAN_EN.
module memory_reader
    import memory_reader_pkg::*;
#(
    parameter int          ADRS_W   = ADRS_W_DEF,
    parameter int          DATA_W   = DATA_W_DEF,
    parameter int          RD_LAT   = 1,
    parameter logic [23:0] SCAN_DIV = 24'd5000000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_in,
    input  logic                 step_in,
    input  logic [ADRS_W-1:0]    adrs_in,
    input  logic                 scan_en,
    memory_reader_if.master      mem,
    output logic [ADRS_W-1:0]    view_adrs,
    output logic [DATA_W-1:0]    view_data,
    output logic                 view_valid,
    output logic                 busy,
    output logic                 wrap
);
    localparam logic [ADRS_W-1:0] ADRS_ONE = 1;

    rd_state_t   state;
    logic [1:0]  lat_cnt;
    logic [1:0]  rise;
    logic        tick;

    // rise[0] = load, rise[1] = step
    for (genvar g = 0; g < 2; g++) begin : g_rise
        memory_reader_rise_detect u_rise (
            .clock (clock),
            .reset (reset),
            .din   (g == 0 ? load_in : step_in),
            .rise  (rise[g])
        );
    end

`ifdef MEMORY_READER_AUTOSCAN_EN
    logic [23:0] scan_cnt;

    assign tick = scan_en && (state == RD_IDLE) && (scan_cnt == SCAN_DIV - 24'd1);

    always_ff @(posedge clock) begin
        if (reset || !scan_en)    scan_cnt <= '0;
        else if (tick)            scan_cnt <= '0;
        else if (state == RD_IDLE) scan_cnt <= scan_cnt + 24'd1;
    end
`else
    logic unused_scan;
    assign unused_scan = scan_en ^ (SCAN_DIV == 24'd0);
    assign tick        = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= RD_IDLE;
            lat_cnt       <= '0;
            mem.mem_adrs  <= '0;
            mem.mem_rd_en <= 1'b0;
            view_adrs     <= '0;
            view_data     <= '0;
            view_valid    <= 1'b0;
            busy          <= 1'b0;
            wrap          <= 1'b0;
        end else begin
            wrap          <= 1'b0;
            mem.mem_rd_en <= 1'b0;
            case (state)
                RD_IDLE: begin
                    // load outranks step; auto-scan tick shares the step path
                    if (rise[0] || rise[1] || tick) begin
                        if (rise[0]) begin
                            mem.mem_adrs <= adrs_in;
                        end else begin
                            mem.mem_adrs <= mem.mem_adrs + ADRS_ONE;
                            wrap         <= &mem.mem_adrs;
                        end
                        view_valid    <= 1'b0;
                        mem.mem_rd_en <= 1'b1;
                        busy          <= 1'b1;
                        state         <= RD_READ;
                    end
                end
                RD_READ: begin
                    lat_cnt <= 2'(RD_LAT - 1);
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        view_data  <= mem.mem_q;
                        view_adrs  <= mem.mem_adrs;
                        view_valid <= 1'b1;
                        busy       <= 1'b0;
                        state      <= RD_IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_reader.sv
// Directed bench: three readers (RD_LAT 1..3) share stimulus, each with its own latency RAM model.
module tb_memory_reader;

    logic       clock = 1'b0;
    logic       reset;
    logic       load_in, step_in;
    logic [7:0] adrs_in;
    logic [2:0] scan_a;

    logic [2:0]      busy_a, vld_a, rd_a, wrap_a;
    logic [2:0][7:0] va_a, vd_a, ma_a;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = g + 1;
        memory_reader_if #(.ADRS_W(8), .DATA_W(8)) mif ();
        logic [7:0] ram [256];
        logic [7:0] qp  [L];

        initial for (int a = 0; a < 256; a++) ram[a] = 8'(a) ^ 8'h5A;

        always @(posedge clock) begin
            qp[0] <= ram[mif.mem_adrs];
            for (int k = 1; k < L; k++) qp[k] <= qp[k-1];
        end
        assign mif.mem_q = qp[L-1];
        assign rd_a[g]   = mif.mem_rd_en;
        assign ma_a[g]   = mif.mem_adrs;

        memory_reader #(.ADRS_W(8), .DATA_W(8), .RD_LAT(L), .SCAN_DIV(24'd4)) dut (
            .clock      (clock),
            .reset      (reset),
            .load_in    (load_in),
            .step_in    (step_in),
            .adrs_in    (adrs_in),
            .scan_en    (scan_a[g]),
            .mem        (mif),
            .view_adrs  (va_a[g]),
            .view_data  (vd_a[g]),
            .view_valid (vld_a[g]),
            .busy       (busy_a[g]),
            .wrap       (wrap_a[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // one event, then cycle-by-cycle timing checks and final view check per latency
    task automatic do_event(input logic ld, input logic st, input logic [7:0] a,
                            input logic exp_wrap, input logic [7:0] exp_adrs);
        @(negedge clock);
        load_in = ld; step_in = st; adrs_in = a;
        @(posedge clock);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rd_en L%0d k%0d", i+1, k), rd_a[i], k == 0);
                chk($sformatf("busy L%0d k%0d", i+1, k), busy_a[i], k <= i + 1);
                chk($sformatf("valid L%0d k%0d", i+1, k), vld_a[i], k >= i + 2);
                chk($sformatf("wrap L%0d k%0d", i+1, k), wrap_a[i], exp_wrap && k == 0);
                chk($sformatf("mem_adrs L%0d k%0d", i+1, k), ma_a[i], exp_adrs);
            end
        end
        load_in = 1'b0; step_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("view_adrs L%0d", i+1), va_a[i], exp_adrs);
            chk($sformatf("view_data L%0d", i+1), vd_a[i], exp_adrs ^ 8'h5A);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s L%0d", tag, i+1),
                {ma_a[i], va_a[i], vd_a[i], rd_a[i], vld_a[i], busy_a[i], wrap_a[i]}, '0);
    endtask

    initial begin
        logic [2:0] seen_rd, seen_busy, vprev;
        int         ncap [3];
        logic [7:0] cap  [3][3];

        reset = 1'b1; load_in = 1'b0; step_in = 1'b0; adrs_in = 8'h00; scan_a = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk_reset_vals("reset");

        // quiet inputs: nothing may start
        seen_rd = '0; seen_busy = '0;
        repeat (100) begin
            @(negedge clock);
            seen_rd |= rd_a; seen_busy |= busy_a;
        end
        chk("idle rd_en", seen_rd, 3'b000);
        chk("idle busy", seen_busy, 3'b000);

        do_event(1'b1, 1'b0, 8'h3C, 1'b0, 8'h3C);
        do_event(1'b1, 1'b0, 8'hFF, 1'b0, 8'hFF);
        do_event(1'b0, 1'b1, 8'hAA, 1'b1, 8'h00);
        do_event(1'b1, 1'b1, 8'h10, 1'b0, 8'h10);

        // step rising while busy is dropped
        @(negedge clock);
        load_in = 1'b1; adrs_in = 8'h20;
        @(negedge clock);
        step_in = 1'b1;
        seen_rd = '0;
        repeat (6) begin
            @(negedge clock);
            seen_rd |= rd_a;
        end
        load_in = 1'b0; step_in = 1'b0;
        chk("busy step rd_en", seen_rd, 3'b000);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy step adrs L%0d", i+1), va_a[i], 8'h20);
            chk($sformatf("busy step data L%0d", i+1), vd_a[i], 8'h7A);
        end
        do_event(1'b0, 1'b1, 8'h00, 1'b0, 8'h21);

        // reset while in WAIT for every latency
        @(negedge clock);
        load_in = 1'b1; adrs_in = 8'h55;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1; load_in = 1'b0;
        @(negedge clock);
        chk_reset_vals("mid reset");
        reset = 1'b0;
        seen_rd = '0; seen_busy = '0; vprev = '0;
        repeat (6) begin
            @(negedge clock);
            seen_rd |= rd_a; seen_busy |= busy_a; vprev |= vld_a;
        end
        chk("post reset rd_en", seen_rd, 3'b000);
        chk("post reset valid", vprev, 3'b000);
        for (int i = 0; i < 3; i++)
            chk($sformatf("post reset data L%0d", i+1), vd_a[i], 8'h00);

`ifdef MEMORY_READER_AUTOSCAN_EN
        // address is 00 after reset; each reader is stopped after its third capture
        for (int i = 0; i < 3; i++) ncap[i] = 0;
        vprev = vld_a;
        scan_a = 3'b111;
        for (int c = 0; c < 150 && scan_a != 3'b000; c++) begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) begin
                if (vld_a[i] && !vprev[i] && ncap[i] < 3) begin
                    cap[i][ncap[i]] = va_a[i];
                    ncap[i]++;
                    if (ncap[i] == 3) scan_a[i] = 1'b0;
                end
            end
            vprev = vld_a;
        end
        scan_a = '0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("scan count L%0d", i+1), ncap[i], 3);
            for (int j = 0; j < 3; j++)
                if (j < ncap[i])
                    chk($sformatf("scan adrs L%0d #%0d", i+1, j), cap[i][j], j + 1);
        end
`else
        // scan_en has no effect without the auto-scan build
        scan_a = 3'b111;
        seen_rd = '0;
        repeat (40) begin
            @(negedge clock);
            seen_rd |= rd_a;
        end
        chk("no autoscan rd_en", seen_rd, 3'b000);
        scan_a = '0;
`endif

        seen_rd = '0;
        repeat (40) begin
            @(negedge clock);
            seen_rd |= rd_a;
        end
        chk("scan off rd_en", seen_rd, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
